// File: rtl/flow_pkg.sv
// flow_pkg: shared definitions for the program-flow sequencer.
//   - flow-op opcodes as seen on op_code
//   - sequencer FSM state encoding
package flow_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_JMP   = 3'd1;
  localparam logic [2:0] OP_JMPC  = 3'd2;
  localparam logic [2:0] OP_JMPCN = 3'd3;
  localparam logic [2:0] OP_CAL   = 3'd4;
  localparam logic [2:0] OP_RET   = 3'd5;
  localparam logic [2:0] OP_HALT  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;  // treated as NOP

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: hardware return-address LIFO.
// Ports:
//   clk, reset     clock, asynchronous active-high reset (clears occupancy only)
//   push, pop      requests; never both in the same cycle
//   din            address to push
//   top            current top-of-stack (valid when !empty), read combinationally
//   full, empty    occupancy flags
//   count          occupancy, 0..DEPTH
//   fault          pulse: push while full or pop while empty (request dropped)
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               top,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       fault
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [W-1:0]    mem [DEPTH];
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] top_idx;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign fault   = (push & full) | (pop & empty);
  assign count   = count_q;

  // Only meaningful when not empty; wraps harmlessly otherwise.
  assign top_idx = count_q - CntW'(1);
  assign top     = mem[top_idx[PtrW-1:0]];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[count_q[PtrW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (do_push) begin
      count_q <= count_q + CntW'(1);
    end else if (do_pop) begin
      count_q <= count_q - CntW'(1);
    end
  end

endmodule

// File: rtl/flow_sequencer.sv
// flow_sequencer: resolves execute-stage flow ops into PC redirects.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   op_valid, op_code   flow op in execute (NOP/JMP/JMPC/JMPCN/CAL/RET/HALT)
//   target, cond        jump/call destination and ALU condition flag
//   pc_cur              address of the instruction in execute
//   resume              leave the halted state
//   branch, pc_target   drive the program counter's branch/pcIn (same-cycle)
//   flush               kill fetch/decode contents
//   halted              core is held in HALT
//   stack_err           sticky return-stack overflow/underflow
//   depth               return-stack occupancy
// Halt is implemented by re-branching to halt_pc every cycle so the PC needs
// no enable input.
module flow_sequencer
  import flow_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       op_valid,
  input  logic [2:0]                 op_code,
  input  logic [ADDR_W-1:0]          target,
  input  logic                       cond,
  input  logic [ADDR_W-1:0]          pc_cur,
  input  logic                       resume,
  output logic                       branch,
  output logic [ADDR_W-1:0]          pc_target,
  output logic                       flush,
  output logic                       halted,
  output logic                       stack_err,
  output logic [$clog2(DEPTH+1)-1:0] depth
);

  localparam int unsigned CntW = $clog2(FLUSH_CYC + 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
  logic              err_q;

  logic              accept;
  logic              push;
  logic              pop;
  logic              fault;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] pc_inc;
  logic              stk_full;
  logic              stk_empty;

  // Gating with reset keeps the Mealy outputs at zero while reset is held.
  assign accept = (state_q == ST_RUN) & op_valid & ~reset;
  assign push   = accept & (op_code == OP_CAL);
  assign pop    = accept & (op_code == OP_RET);
  assign pc_inc = pc_cur + ADDR_W'(1);

  ret_stack #(
    .DEPTH (DEPTH),
    .W     (ADDR_W)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .top   (top),
    .full  (stk_full),
    .empty (stk_empty),
    .count (depth),
    .fault (fault)
  );

  always_comb begin
    logic              take;
    logic              do_halt;
    logic [ADDR_W-1:0] tgt;

    state_d   = state_q;
    cnt_d     = cnt_q;
    halt_pc_d = halt_pc_q;
    branch    = 1'b0;
    pc_target = '0;
    flush     = 1'b0;
    halted    = 1'b0;
    take      = 1'b0;
    do_halt   = 1'b0;
    tgt       = target;

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          case (op_code)
            OP_JMP:   take = 1'b1;
            OP_JMPC:  take = cond;
            OP_JMPCN: take = ~cond;
            OP_CAL:   take = 1'b1;
            OP_RET: begin
              take = 1'b1;
              tgt  = top;
            end
            OP_HALT:  do_halt = 1'b1;
            default:  take = 1'b0;
          endcase
          // A stack fault turns the CAL/RET into a halt at the next address.
          if (fault) begin
            do_halt = 1'b1;
          end
        end
        if (do_halt) begin
          branch    = 1'b1;
          pc_target = pc_inc;
          flush     = 1'b1;
          halt_pc_d = pc_inc;
          state_d   = ST_HALT;
        end else if (take) begin
          branch    = 1'b1;
          pc_target = tgt;
          flush     = 1'b1;
          cnt_d     = CntW'(FLUSH_CYC - 1);
          state_d   = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_HALT: begin
        branch    = 1'b1;
        pc_target = halt_pc_q;
        flush     = 1'b1;
        halted    = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      halt_pc_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      halt_pc_q <= halt_pc_d;
      err_q     <= err_q | fault;
    end
  end

  assign stack_err = err_q;

endmodule

// File: doc/flow_sequencer.md
# flow_sequencer

Program-flow controller that drives the program counter's `branch` and `pcIn` inputs. It takes flow-control operations decoded in the execute stage: jumps, conditional jumps, call, return and halt. It resolves them against the condition flag and keeps a hardware return-address stack. It also flushes wrong-path instructions and holds the core during halt by re-branching each cycle, so the existing program counter needs no enable pin.

## Interface
- `ADDR_W`, 8: instruction address width; equals the codebase instruction-length define.
- `DEPTH`, 4: return-stack entries (power of two, ≥2).
- `FLUSH_CYC`, 2: extra flush cycles after a taken redirect (≥1).
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `op_valid`  in  1  a flow op is present in execute this cycle.
- `op_code`  in  3  0 NOP, 1 JMP, 2 JMPC, 3 JMPCN, 4 CAL, 5 RET, 6 HALT, 7 NOP (reserved).
- `target`  in  ADDR_W  jump/call destination.
- `cond`  in  1  condition flag (result register) from the ALU.
- `pc_cur`  in  ADDR_W  address of the instruction in execute.
- `resume`  in  1  leave HALT (peripheral/debug request).
- `branch`  out  1  to program counter `branch`.
- `pc_target`  out  ADDR_W  to program counter `pcIn`.
- `flush`  out  1  kill fetch/decode stage contents.
- `halted`  out  1  core is halted.
- `stack_err`  out  1  sticky stack overflow/underflow flag.
- `depth`  out  $clog2(DEPTH+1)  current stack occupancy.

## Operation
- States: RUN, FLUSH, HALT.
- RUN, op accepted when `op_valid`=1. Redirect outputs are combinational (Mealy) from the op.
  - JMP: `branch`=1, `pc_target`=`target`.
  - JMPC: same, only when `cond`=1.
  - JMPCN: same, only when `cond`=0.
  - CAL: push `pc_cur`+1 (mod 2^ADDR_W), then redirect to `target`.
  - RET: pop, then redirect to the popped value.
  - HALT: `branch`=1, `pc_target`=`pc_cur`+1; latch that address as `halt_pc`.
- Taken redirect in cycle N: `flush`=1 in cycle N, then go to FLUSH. Untaken conditional jump or NOP: no branch, no flush, stay in RUN.
- FLUSH: `flush`=1 for exactly FLUSH_CYC cycles, counted by a down-counter. `op_valid` is ignored, with no push or pop. Then return to RUN.
- HALT state: each cycle `branch`=1, `pc_target`=`halt_pc`, `flush`=1, `halted`=1.
  - `resume`=1 in cycle M: HALT outputs still held in cycle M; RUN from M+1.
  - The PC then fetches `halt_pc` and increments normally.
- Stack faults:
  - CAL with `depth`=DEPTH is an overflow: no push.
  - RET with `depth`=0 is an underflow: no pop.
  - On either fault: `stack_err` set (sticky), and the op behaves as HALT with `halt_pc`=`pc_cur`+1.
  - Only reset clears `stack_err`; `resume` does not.
- Reset, asynchronous, at any point including mid-FLUSH or HALT:
  - state returns to RUN; `depth`=0; stack contents don't-care; `halt_pc`=0.
  - outputs: `branch`=0, `pc_target`=0, `flush`=0, `halted`=0, `stack_err`=0.
- In RUN, when no branch is taken, `pc_target` = 0.

## Timing
- Redirect latency is 0 cycles: an op in cycle N gives `branch`/`pc_target` in cycle N, and the PC holds the target after edge N.
- `depth` updates at edge N.
- A CAL followed immediately by a RET cannot both execute: the RET falls in the FLUSH window and is ignored by design, since it is a wrong-path instruction.
- `depth` never exceeds DEPTH and never goes below 0.

## Structure
- Package `flow_pkg`: opcode localparams (OP_NOP…OP_HALT), state encoding (ST_RUN, ST_FLUSH, ST_HALT).
- Sub-module `ret_stack`: LIFO with push/pop, `full`/`empty`, occupancy count, and top-of-stack read.
  - Pop returns the current top combinationally.
  - Full/empty guards sit inside `ret_stack`, and it reports the fault pulse.
- Top level: FSM, flush counter, `halt_pc` register, output muxing.

## Test plan
- Reset, then `op_valid`=1, JMP to 0x40 at `pc_cur`=0x10: `branch`=1, `pc_target`=0x40 same cycle; `flush` high for 3 consecutive cycles (N plus FLUSH_CYC=2); back in RUN.
- JMPC with `cond`=0 and JMPCN with `cond`=1: `branch`=0, `flush`=0, state stays RUN.
- CAL 0x80 from 0x12, then RET after the flush window:
  - CAL: `depth` 0→1, target 0x80.
  - RET: `pc_target`=0x13, `depth`→0.
  - Nested 4 calls return in LIFO order.
- Call-stack faults:
  - Fifth CAL with DEPTH=4 from 0x30: `stack_err`=1, `halted`=1, `pc_target`=0x31, `depth` stays 4.
  - RET on an empty stack also faults.
  - `stack_err` stays set across `resume`.
- HALT at 0xFF: `halt_pc` wraps to 0x00 and is driven each cycle with `flush`=1. `resume` pulse: RUN next cycle, `branch`=0.
- Assert `reset` mid-FLUSH and mid-HALT: all outputs go to 0 asynchronously and RUN resumes after release.
